btn_debounce_move: RTL and testbench

- Consumes the 1 ms tick from the 26-bit clock divider and debounces the five Nexys3 push buttons (up, down, left, right, centre).
- Produces clean levels and one-cycle press pulses.
- Turns direction presses into a held move request with a valid/ack handshake to the 2048 game-logic FSM.
- Turns a centre press into a restart pulse.

---
 rtl/btn_debounce_move.sv | 173 +++++++++++++++++
 tb/tb_btn_debounce_move.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_move.sv
// Push-button front end for the 2048 game.
// Synchronizes and debounces the five buttons on the 1 ms tick, produces clean
// levels and one-cycle press pulses, and turns direction presses into a held
// move request with a valid/ack handshake. A centre press becomes a restart pulse.
module btn_debounce_move #(
    parameter int unsigned NUM_BTN     = 5,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_1ms,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic               move_valid,
    output logic [1:0]         move_dir,
    input  logic               move_ack,
    output logic               restart_pulse
);

    // Button bit positions
    localparam int unsigned BtnUp     = 0;
    localparam int unsigned BtnDown   = 1;
    localparam int unsigned BtnLeft   = 2;
    localparam int unsigned BtnRight  = 3;
    localparam int unsigned BtnCentre = 4;

    // Count value on which the next tick accepts the new level
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_MS - 1);

    typedef enum logic [0:0] {
        StIdle,
        StPend
    } move_state_e;

    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;
    logic               tick_q;
    logic               tick_en;

    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] level_q;
    logic [NUM_BTN-1:0] level_d;
    logic [NUM_BTN-1:0] press_q;
    logic [NUM_BTN-1:0] press_d;
    logic               restart_q;
    logic               restart_d;

    move_state_e        state_q;
    move_state_e        state_d;
    logic [1:0]         dir_q;
    logic [1:0]         dir_d;
    logic               dir_press;
    logic [1:0]         prio_dir;

    // Two-flop synchronizer for the raw pins and the tick delay register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            tick_q  <= tick_1ms;
        end
    end

    // One enable per tick regardless of how long the tick stays high
    assign tick_en = tick_1ms & ~tick_q;

    // Per-button debounce counters; any cycle matching the current level restarts the count
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < int'(NUM_BTN); i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick_en) begin
                if (cnt_q[i] == CntMax) begin
                    level_d[i] = sync2_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        // Pulse in the first cycle the new high level is visible
        press_d   = level_d & ~level_q;
        restart_d = press_d[BtnCentre];
    end

    // Debounce state, press pulses and restart pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                cnt_q[i] <= '0;
            end
            level_q   <= '0;
            press_q   <= '0;
            restart_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q   <= level_d;
            press_q   <= press_d;
            restart_q <= restart_d;
        end
    end

    // Fixed priority up > down > left > right among direction presses
    always_comb begin
        dir_press = press_q[BtnUp] | press_q[BtnDown] | press_q[BtnLeft] | press_q[BtnRight];
        prio_dir  = 2'b11;
        if (press_q[BtnUp]) begin
            prio_dir = 2'b00;
        end else if (press_q[BtnDown]) begin
            prio_dir = 2'b01;
        end else if (press_q[BtnLeft]) begin
            prio_dir = 2'b10;
        end else begin
            prio_dir = 2'b11;
        end
    end

    // Move handshake next state: presses without an ack while pending are dropped
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        unique case (state_q)
            StIdle: begin
                if (dir_press) begin
                    dir_d   = prio_dir;
                    state_d = StPend;
                end
            end
            StPend: begin
                if (move_ack) begin
                    if (dir_press) begin
                        // Back-to-back move: valid stays high with no gap
                        dir_d = prio_dir;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Move handshake state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            dir_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
        end
    end

    assign btn_level     = level_q;
    assign btn_press     = press_q;
    assign restart_pulse = restart_q;
    assign move_valid    = (state_q == StPend);
    assign move_dir      = dir_q;

endmodule

// File: tb/tb_btn_debounce_move.sv
// Directed bench for btn_debounce_move with DEBOUNCE_MS=4 and a 2-cycle tick every 10 clk.
module tb_btn_debounce_move;

    localparam int unsigned NUM_BTN = 5;

    logic               clk;
    logic               rst_n;
    logic               tick_1ms;
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic               move_valid;
    logic [1:0]         move_dir;
    logic               move_ack;
    logic               restart_pulse;

    int tests;
    int failed;
    int press_cnt [NUM_BTN];
    int restart_cnt;
    int snap;

    btn_debounce_move #(
        .NUM_BTN    (NUM_BTN),
        .DEBOUNCE_MS(4),
        .CNT_W      (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_1ms     (tick_1ms),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .btn_press    (btn_press),
        .move_valid   (move_valid),
        .move_dir     (move_dir),
        .move_ack     (move_ack),
        .restart_pulse(restart_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every press / restart pulse so dropped or spurious pulses are visible later
    initial begin
        for (int i = 0; i < int'(NUM_BTN); i++) press_cnt[i] = 0;
        restart_cnt = 0;
    end
    always @(posedge clk) begin
        for (int i = 0; i < int'(NUM_BTN); i++) begin
            if (btn_press[i] === 1'b1) press_cnt[i] <= press_cnt[i] + 1;
        end
        if (restart_pulse === 1'b1) restart_cnt <= restart_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Rising edge of the tick is sampled by the edge inside tick_edge
    task automatic tick_edge();
        tick_1ms = 1'b1;
        cyc(1);
    endtask

    task automatic tick_tail();
        cyc(1);
        tick_1ms = 1'b0;
        cyc(8);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick_edge();
            tick_tail();
        end
    endtask

    initial begin
        tests    = 0;
        failed   = 0;
        rst_n    = 1'b0;
        tick_1ms = 1'b0;
        move_ack = 1'b0;
        btn_raw  = 5'h1F;

        // Reset with all buttons held
        cyc(2);
        check("rst_level", 32'(btn_level), 32'h0);
        check("rst_press", 32'(btn_press), 32'h0);
        check("rst_valid", 32'(move_valid), 32'h0);
        check("rst_dir", 32'(move_dir), 32'h0);
        check("rst_restart", 32'(restart_pulse), 32'h0);
        rst_n = 1'b1;
        cyc(3);
        ticks(3);
        check("hold_level_3ticks", 32'(btn_level), 32'h0);
        tick_edge();
        check("hold_level_4th", 32'(btn_level), 32'h1F);
        check("hold_press", 32'(btn_press), 32'h1F);
        check("hold_restart", 32'(restart_pulse), 32'h1);
        cyc(1);
        check("hold_press_gone", 32'(btn_press), 32'h0);
        check("hold_restart_gone", 32'(restart_pulse), 32'h0);
        check("hold_valid", 32'(move_valid), 32'h1);
        check("hold_dir_up", 32'(move_dir), 32'h0);
        tick_1ms = 1'b0;
        cyc(8);
        move_ack = 1'b1;
        cyc(1);
        move_ack = 1'b0;
        check("hold_ack_idle", 32'(move_valid), 32'h0);

        // Release everything: no pulses on release
        snap = press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] + press_cnt[4];
        btn_raw = 5'h00;
        cyc(3);
        ticks(4);
        check("release_level", 32'(btn_level), 32'h0);
        check("release_no_press",
              32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] + press_cnt[4]),
              32'(snap));

        // Bounce on left, then settle high
        snap = press_cnt[2];
        fork
            ticks(10);
            begin
                repeat (14) begin
                    btn_raw[2] = ~btn_raw[2];
                    cyc(7);
                end
            end
        join
        check("bounce_no_press", 32'(press_cnt[2]), 32'(snap));
        check("bounce_level", 32'(btn_level), 32'h0);
        btn_raw = 5'h04;
        cyc(3);
        ticks(3);
        check("bounce_settle_3", 32'(btn_level), 32'h0);
        tick_edge();
        check("bounce_settle_4", 32'(btn_level), 32'h04);
        check("bounce_press", 32'(btn_press), 32'h04);
        cyc(1);
        check("bounce_valid", 32'(move_valid), 32'h1);
        check("bounce_dir_left", 32'(move_dir), 32'h2);
        tick_1ms = 1'b0;
        cyc(8);
        move_ack = 1'b1;
        cyc(1);
        move_ack = 1'b0;
        check("bounce_ack", 32'(move_valid), 32'h0);
        btn_raw = 5'h00;
        cyc(3);
        ticks(4);

        // Handshake hold: right pending, up press dropped
        btn_raw = 5'h08;
        cyc(3);
        ticks(4);
        check("hs_valid", 32'(move_valid), 32'h1);
        check("hs_dir_right", 32'(move_dir), 32'h3);
        snap = press_cnt[0];
        btn_raw = 5'h09;
        cyc(3);
        ticks(4);
        check("hs_up_pressed", 32'(press_cnt[0]), 32'(snap + 1));
        cyc(120);
        check("hs_dir_held", 32'(move_dir), 32'h3);
        check("hs_valid_held", 32'(move_valid), 32'h1);
        move_ack = 1'b1;
        cyc(1);
        move_ack = 1'b0;
        check("hs_ack_clears", 32'(move_valid), 32'h0);
        cyc(5);
        check("hs_up_dropped", 32'(move_valid), 32'h0);
        btn_raw = 5'h00;
        cyc(3);
        ticks(4);

        // Ack while idle is ignored
        move_ack = 1'b1;
        cyc(2);
        move_ack = 1'b0;
        check("idle_ack_ignored", 32'(move_valid), 32'h0);

        // Priority: down and left together
        btn_raw = 5'h06;
        cyc(3);
        ticks(3);
        tick_edge();
        check("prio_press", 32'(btn_press), 32'h06);
        cyc(1);
        check("prio_valid", 32'(move_valid), 32'h1);
        check("prio_dir_down", 32'(move_dir), 32'h1);
        tick_1ms = 1'b0;
        cyc(8);

        // Back-to-back: ack coincides with a new right press
        btn_raw = 5'h0E;
        cyc(3);
        ticks(3);
        tick_edge();
        check("b2b_press_right", 32'(btn_press), 32'h08);
        move_ack = 1'b1;
        cyc(1);
        move_ack = 1'b0;
        check("b2b_valid", 32'(move_valid), 32'h1);
        check("b2b_dir_right", 32'(move_dir), 32'h3);
        tick_1ms = 1'b0;
        cyc(8);
        check("b2b_valid_held", 32'(move_valid), 32'h1);
        move_ack = 1'b1;
        cyc(1);
        move_ack = 1'b0;
        check("b2b_ack_clears", 32'(move_valid), 32'h0);
        btn_raw = 5'h00;
        cyc(3);
        ticks(4);

        // Release with a glitch in the middle
        btn_raw = 5'h01;
        cyc(3);
        ticks(4);
        check("gl_valid", 32'(move_valid), 32'h1);
        check("gl_dir_up", 32'(move_dir), 32'h0);
        snap = press_cnt[0];
        btn_raw = 5'h00;
        cyc(3);
        ticks(3);
        btn_raw = 5'h01;
        cyc(1);
        btn_raw = 5'h00;
        cyc(3);
        ticks(3);
        check("gl_level_held", 32'(btn_level), 32'h01);
        tick_edge();
        check("gl_level_fell", 32'(btn_level), 32'h00);
        tick_tail();
        check("gl_no_press", 32'(press_cnt[0]), 32'(snap));
        check("gl_valid_kept", 32'(move_valid), 32'h1);
        check("gl_dir_kept", 32'(move_dir), 32'h0);
        check("restart_once", 32'(restart_cnt), 32'h1);

        // Async reset while pending with down partly counted
        btn_raw = 5'h02;
        cyc(3);
        ticks(2);
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(move_valid), 32'h0);
        check("ar_level", 32'(btn_level), 32'h0);
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
        ticks(3);
        check("ar_recount_3", 32'(btn_level), 32'h0);
        tick_edge();
        check("ar_recount_4", 32'(btn_level), 32'h02);
        check("ar_press", 32'(btn_press), 32'h02);
        cyc(1);
        check("ar_valid_again", 32'(move_valid), 32'h1);
        check("ar_dir_down", 32'(move_dir), 32'h1);
        tick_1ms = 1'b0;
        cyc(8);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
